// File: rtl/spi_flash_target.sv
// rtl/spi_flash_target.sv - SPI NOR flash responder serving READ (0x03) from preloadable byte RAM
module spi_flash_target #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flash_csb,
    input  logic          flash_clk,
    input  logic          flash_io0_di,
    output logic          flash_io1_do,
    output logic          flash_io1_oe,
    input  logic          pre_we,
    input  logic [AW-1:0] pre_addr,
    input  logic [7:0]    pre_wdata,
    output logic          busy,
    output logic [7:0]    last_cmd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_IGNORE
    } state_t;

    state_t        state;

    logic          csb_s1;
    logic          csb_s2;
    logic          sck_s1;
    logic          sck_s2;
    logic          sck_d;
    logic          io0_s1;
    logic          io0_s2;
    logic          sck_rise;
    logic          sck_fall;

    logic [2:0]    bit_cnt;
    logic [4:0]    addr_cnt;
    logic [6:0]    cmd_sh;
    logic [7:0]    cmd_byte;
    logic [AW-1:0] addr_sh;
    logic [6:0]    data_sh;

    logic [7:0]    mem [0:MEM_BYTES-1];
    logic [AW-1:0] rd_idx;
    logic          rd_en;
    logic [7:0]    rd_data;

    // Synchronisers reset to the idle bus levels so no phantom edge follows reset release.
    always_ff @(posedge clk) begin
        if (reset) begin
            csb_s1 <= 1'b1;
            csb_s2 <= 1'b1;
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_d  <= 1'b0;
            io0_s1 <= 1'b0;
            io0_s2 <= 1'b0;
        end else begin
            csb_s1 <= flash_csb;
            csb_s2 <= csb_s1;
            sck_s1 <= flash_clk;
            sck_s2 <= sck_s1;
            sck_d  <= sck_s2;
            io0_s1 <= flash_io0_di;
            io0_s2 <= io0_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;
    assign cmd_byte = {cmd_sh, io0_s2};
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            flash_io1_do <= 1'b0;
            flash_io1_oe <= 1'b0;
            last_cmd     <= 8'h00;
            bit_cnt      <= 3'd0;
            addr_cnt     <= 5'd0;
            cmd_sh       <= 7'd0;
            addr_sh      <= '0;
            data_sh      <= 7'd0;
            rd_idx       <= '0;
            rd_en        <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            if (csb_s2) begin
                state        <= S_IDLE;
                flash_io1_do <= 1'b0;
                flash_io1_oe <= 1'b0;
                bit_cnt      <= 3'd0;
                addr_cnt     <= 5'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_CMD;
                        bit_cnt <= 3'd0;
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            cmd_sh  <= cmd_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                last_cmd <= cmd_byte;
                                bit_cnt  <= 3'd0;
                                addr_cnt <= 5'd0;
                                state    <= (cmd_byte == 8'h03) ? S_ADDR : S_IGNORE;
                            end
                        end
                    end
                    S_ADDR: begin
                        // Only the low AW address bits survive the shift; upper bits fall off.
                        if (sck_rise) begin
                            addr_sh  <= {addr_sh[AW-2:0], io0_s2};
                            addr_cnt <= addr_cnt + 5'd1;
                            if (addr_cnt == 5'd23) begin
                                rd_idx  <= {addr_sh[AW-2:0], io0_s2};
                                rd_en   <= 1'b1;
                                bit_cnt <= 3'd0;
                                state   <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (sck_fall) begin
                            flash_io1_oe <= 1'b1;
                            bit_cnt      <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd0) begin
                                // Byte boundary: consume the prefetch and fetch the following byte.
                                flash_io1_do <= rd_data[7];
                                data_sh      <= rd_data[6:0];
                                rd_idx       <= rd_idx + {{(AW-1){1'b0}}, 1'b1};
                                rd_en        <= 1'b1;
                            end else begin
                                flash_io1_do <= data_sh[6];
                                data_sh      <= {data_sh[5:0], 1'b0};
                            end
                        end
                    end
                    S_IGNORE: begin
                        flash_io1_oe <= 1'b0;
                        flash_io1_do <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Read-before-write: a same-cycle preload to the read address yields the old byte.
    always_ff @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_wdata;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_spi_flash_target.sv
// tb/tb_spi_flash_target.sv - scoreboard bench for spi_flash_target
module tb_spi_flash_target;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          csb;
    logic          sck;
    logic          mosi;
    logic          miso;
    logic          oe;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [7:0]    pre_wdata;
    logic          busy;
    logic [7:0]    last_cmd;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_q[$];
    logic          saw_oe;
    int            mcnt;
    logic [7:0]    mbyte;
    logic [7:0]    mexp;

    spi_flash_target #(.MEM_BYTES(1024), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flash_csb    (csb),
        .flash_clk    (sck),
        .flash_io0_di (mosi),
        .flash_io1_do (miso),
        .flash_io1_oe (oe),
        .pre_we       (pre_we),
        .pre_addr     (pre_addr),
        .pre_wdata    (pre_wdata),
        .busy         (busy),
        .last_cmd     (last_cmd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            wait_clk(8);
            sck = 1'b1;
            if (oe) saw_oe = 1'b1;
            wait_clk(8);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx);
        spi_bits(tx, 8);
    endtask

    task automatic start_read(input logic [23:0] a);
        csb = 1'b0;
        wait_clk(8);
        spi_byte(8'h03);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
    endtask

    task automatic read_bytes(input int n);
        repeat (n) spi_byte(8'h00);
    endtask

    task automatic end_cs();
        wait_clk(8);
        csb = 1'b1;
        wait_clk(8);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        pre_we    = 1'b1;
        pre_addr  = a;
        pre_wdata = d;
        wait_clk(1);
        pre_we    = 1'b0;
    endtask

    // Monitor: assembles each MISO byte seen on SCK rises while oe is high.
    initial begin
        mcnt  = 0;
        mbyte = 8'h00;
        forever begin
            @(posedge sck or posedge csb or posedge reset);
            if (csb === 1'b1 || reset === 1'b1) begin
                mcnt = 0;
            end else if (oe === 1'b1) begin
                mbyte = {mbyte[6:0], miso};
                mcnt++;
                if (mcnt == 8) begin
                    mcnt = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL miso_unexpected: got %0h expected none", mbyte);
                    end else begin
                        mexp = exp_q.pop_front();
                        if (mbyte !== mexp) begin
                            errors++;
                            $display("FAIL miso_byte: got %0h expected %0h", mbyte, mexp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        csb       = 1'b1;
        sck       = 1'b0;
        mosi      = 1'b0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_wdata = 8'h00;
        saw_oe    = 1'b0;
        wait_clk(3);
        check("reset_oe", 32'(oe), 32'd0);
        check("reset_do", 32'(miso), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_last_cmd", 32'(last_cmd), 32'h00);
        reset = 1'b0;
        wait_clk(3);

        preload(10'h000, 8'h11);
        preload(10'h001, 8'h22);
        preload(10'h002, 8'h33);
        preload(10'h003, 8'h44);
        preload(10'h004, 8'h66);
        preload(10'h005, 8'h77);
        preload(10'h3FE, 8'h5A);
        preload(10'h3FF, 8'hC3);

        // Basic READ at 0
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        start_read(24'h000000);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_last_cmd", 32'(last_cmd), 32'h03);
        read_bytes(4);
        check("t1_oe", 32'(oe), 32'd1);
        end_cs();
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_oe", 32'(oe), 32'd0);

        // Wrap at top of RAM, and upper address bits ignored
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        start_read(24'h0003FE);
        read_bytes(4);
        end_cs();
        exp_q.push_back(8'h22);
        start_read(24'hAB0001);
        read_bytes(1);
        end_cs();

        // Unsupported opcode
        csb = 1'b0;
        wait_clk(40);
        check("t3_cmd_wait_busy", 32'(busy), 32'd1);
        saw_oe = 1'b0;
        spi_byte(8'hAB);
        spi_byte(8'h00);
        spi_byte(8'h00);
        check("t3_last_cmd", 32'(last_cmd), 32'hAB);
        check("t3_saw_oe", 32'(saw_oe), 32'd0);
        check("t3_oe", 32'(oe), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        wait_clk(8);
        csb = 1'b1;
        wait_clk(4);
        check("t3_idle_busy", 32'(busy), 32'd0);
        wait_clk(8);

        // Abort mid-address
        csb = 1'b0;
        wait_clk(8);
        spi_byte(8'h03);
        spi_byte(8'h00);
        spi_bits(8'h00, 4);
        wait_clk(8);
        csb = 1'b1;
        wait_clk(3);
        check("t4_oe", 32'(oe), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        wait_clk(8);
        exp_q.push_back(8'h33);
        start_read(24'h000002);
        read_bytes(1);
        end_cs();

        // Reset during data byte 2
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        start_read(24'h000000);
        read_bytes(2);
        spi_bits(8'h00, 3);
        reset = 1'b1;
        wait_clk(1);
        check("t5_oe", 32'(oe), 32'd0);
        check("t5_do", 32'(miso), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        csb = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(4);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        start_read(24'h000002);
        read_bytes(2);
        end_cs();

        // Preload while streaming
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        exp_q.push_back(8'h66); exp_q.push_back(8'hA5);
        start_read(24'h000000);
        fork
            read_bytes(6);
            begin
                wait_clk(100);
                preload(10'h005, 8'hA5);
            end
        join
        end_cs();

        wait_clk(10);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
